// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache with one
// 32-bit word per line, placed between the CPU data port and memory port B.
// Read hits complete in one cycle; misses and all writes go to memory.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   addr            CPU byte address (bits [1:0] ignored)
//   data_i, data_en CPU write data and byte enables
//   write_en        CPU write request (wins when read_en is also high)
//   read_en         CPU read request
//   flush           invalidate every line; only acted on in IDLE with no request
//   data_o, hit     read data / hit flag of the completing access, valid with done
//   done            one-cycle completion pulse
//   mem_*           request side of memory port B (registered)
//   mem_data_i      memory read data, sampled only with mem_done in MEM_WAIT
//   mem_done        memory completion
module dcache #(
    parameter int MEM_SIZE  = 4096,
    parameter int NUM_LINES = 64,
    localparam int AW = $clog2(MEM_SIZE),
    localparam int IW = $clog2(NUM_LINES),
    localparam int TW = AW - IW - 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   data_i,
    input  logic [3:0]    data_en,
    input  logic          write_en,
    input  logic          read_en,
    input  logic          flush,
    output logic [31:0]   data_o,
    output logic          hit,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data_o,
    output logic [3:0]    mem_data_en,
    output logic          mem_write_en,
    output logic          mem_read_en,
    input  logic [31:0]   mem_data_i,
    input  logic          mem_done
);

    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [TW-1:0]          tag_q  [NUM_LINES];
    logic [TW-1:0]          tag_d  [NUM_LINES];
    logic [31:0]            line_q [NUM_LINES];
    logic [31:0]            line_d [NUM_LINES];
    logic                   req_wr_q, req_wr_d;
    logic                   done_q, done_d;
    logic                   hit_q, hit_d;
    logic [31:0]            data_o_q, data_o_d;
    logic [AW-1:0]          mem_addr_q, mem_addr_d;
    logic [31:0]            mem_data_o_q, mem_data_o_d;
    logic [3:0]             mem_data_en_q, mem_data_en_d;
    logic                   mem_read_en_q, mem_read_en_d;
    logic                   mem_write_en_q, mem_write_en_d;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_word[8*b +: 8];
        end
        return r;
    endfunction

    // Lookup for the incoming CPU request (used in IDLE only).
    logic [IW-1:0] cpu_idx;
    logic [TW-1:0] cpu_tag;
    logic          cpu_hit;
    assign cpu_idx = addr[IW+1:2];
    assign cpu_tag = addr[AW-1:IW+2];
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    // The memory request registers double as the latched request, so the
    // outstanding access is looked up again from them when memory answers.
    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic          req_hit;
    assign req_idx = mem_addr_q[IW+1:2];
    assign req_tag = mem_addr_q[AW-1:IW+2];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        tag_d          = tag_q;
        line_d         = line_q;
        req_wr_d       = req_wr_q;
        done_d         = 1'b0;
        hit_d          = hit_q;
        data_o_d       = data_o_q;
        mem_addr_d     = mem_addr_q;
        mem_data_o_d   = mem_data_o_q;
        mem_data_en_d  = mem_data_en_q;
        mem_read_en_d  = 1'b0;
        mem_write_en_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (write_en || read_en) begin
                    if (!write_en && cpu_hit) begin
                        state_d  = RESP;
                        done_d   = 1'b1;
                        hit_d    = 1'b1;
                        data_o_d = line_q[cpu_idx];
                    end else begin
                        // Enables are registered, so they are high exactly
                        // during the MEM_REQ cycle.
                        state_d        = MEM_REQ;
                        req_wr_d       = write_en;
                        mem_read_en_d  = !write_en;
                        mem_write_en_d = write_en;
                        mem_addr_d     = {addr[AW-1:2], 2'b00};
                        mem_data_o_d   = data_i;
                        mem_data_en_d  = data_en;
                    end
                end else if (flush) begin
                    valid_d = '0;
                end
            end
            MEM_REQ: begin
                state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_done) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    if (req_wr_q) begin
                        data_o_d = '0;
                        hit_d    = req_hit;
                        if (req_hit) begin
                            line_d[req_idx] = merge_bytes(line_q[req_idx], mem_data_o_q, mem_data_en_q);
                        end
                    end else begin
                        valid_d[req_idx] = 1'b1;
                        tag_d[req_idx]   = req_tag;
                        line_d[req_idx]  = mem_data_i;
                        data_o_d         = mem_data_i;
                        hit_d            = 1'b0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            valid_q        <= '0;
            req_wr_q       <= 1'b0;
            done_q         <= 1'b0;
            hit_q          <= 1'b0;
            data_o_q       <= '0;
            mem_addr_q     <= '0;
            mem_data_o_q   <= '0;
            mem_data_en_q  <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            req_wr_q       <= req_wr_d;
            done_q         <= done_d;
            hit_q          <= hit_d;
            data_o_q       <= data_o_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_o_q   <= mem_data_o_d;
            mem_data_en_q  <= mem_data_en_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
        end
    end

    // Tag and data storage need no reset: an entry is only trusted via valid_q.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

    assign data_o       = data_o_q;
    assign hit          = hit_q;
    assign done         = done_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_o   = mem_data_o_q;
    assign mem_data_en  = mem_data_en_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;

endmodule

// File: tb/tb_dcache.sv
module tb_dcache;
    localparam int MEM_SIZE  = 4096;
    localparam int NUM_LINES = 64;
    localparam int AW        = 12;
    localparam int WORDS     = MEM_SIZE / 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic [31:0]   data_i;
    logic [3:0]    data_en;
    logic          write_en;
    logic          read_en;
    logic          flush;
    logic [31:0]   data_o;
    logic          hit;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_o;
    logic [3:0]    mem_data_en;
    logic          mem_write_en;
    logic          mem_read_en;
    logic [31:0]   mem_data_i;
    logic          mem_done;

    always #5 clk = ~clk;

    dcache #(.MEM_SIZE(MEM_SIZE), .NUM_LINES(NUM_LINES)) dut (
        .clk(clk), .reset(reset), .addr(addr), .data_i(data_i), .data_en(data_en),
        .write_en(write_en), .read_en(read_en), .flush(flush), .data_o(data_o),
        .hit(hit), .done(done), .mem_addr(mem_addr), .mem_data_o(mem_data_o),
        .mem_data_en(mem_data_en), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_data_i(mem_data_i), .mem_done(mem_done)
    );

    // Memory seen by the DUT, and the memory contents the model expects.
    logic [31:0] mem     [WORDS];
    logic [31:0] exp_mem [WORDS];
    // Model of cache contents: word address -> cached word.
    logic [31:0] cached [int];

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;
    bit noise    = 0;
    int wait_cnt = 0;
    logic [31:0] rd_word;

    function automatic logic [31:0] init_word(input int w);
        return 32'hC000_0000 + 32'(w) * 32'h0001_0003;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Memory port B responder: mem_done arrives mem_lat cycles after the
    // request cycle; optional spurious mem_done pulses while nothing is pending.
    initial begin
        mem_done   = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            mem_done   = 1'b0;
            mem_data_i = $urandom;
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    mem_done   = 1'b1;
                    mem_data_i = rd_word;
                end
            end else if (noise && $urandom_range(0, 5) == 0) begin
                mem_done = 1'b1;
            end
            if (mem_read_en || mem_write_en) begin
                wait_cnt = mem_lat;
                rd_word  = mem[mem_addr[11:2]];
                if (mem_write_en) mem[mem_addr[11:2]] = merge(mem[mem_addr[11:2]], mem_data_o, mem_data_en);
            end
        end
    end

    // Reference model: predicts hit, data and latency of one access.
    task automatic model_access(input logic wr, input logic [11:0] a, input logic [31:0] d,
                                input logic [3:0] be, output logic eh, output logic [31:0] ed,
                                output int el);
        int wa;
        wa = int'(a[11:2]);
        if (wr) begin
            eh = cached.exists(wa);
            ed = '0;
            el = mem_lat + 2;
            exp_mem[wa] = merge(exp_mem[wa], d, be);
            if (eh) cached[wa] = merge(cached[wa], d, be);
        end else if (cached.exists(wa)) begin
            eh = 1'b1;
            ed = cached[wa];
            el = 1;
        end else begin
            eh = 1'b0;
            ed = exp_mem[wa];
            el = mem_lat + 2;
            for (int t = 0; t < WORDS / NUM_LINES; t++) cached.delete(t * NUM_LINES + (wa % NUM_LINES));
            cached[wa] = ed;
        end
    endtask

    // Present one request, wait (bounded) for done and check everything seen.
    task automatic run_access(input string nm, input logic wr, input logic rd, input logic [11:0] a,
                              input logic [31:0] d, input logic [3:0] be, input logic eh,
                              input logic [31:0] ed, input int el);
        int k, en_cnt, en_k;
        logic en_w;
        logic [11:0] en_a;
        bit got;
        addr = a; data_i = d; data_en = be; write_en = wr; read_en = rd;
        k = 0; en_cnt = 0; en_k = -1; en_w = 1'b0; en_a = '0; got = 0;
        while (!got && k < 60) begin
            @(negedge clk);
            if (mem_read_en || mem_write_en) begin
                en_cnt++; en_k = k; en_w = mem_write_en; en_a = mem_addr;
            end
            if (done) got = 1;
            else k++;
        end
        chk({nm, " latency"}, got ? 32'(k) : 32'hFFFF_FFFF, 32'(el));
        chk({nm, " hit"}, {31'b0, hit}, {31'b0, eh});
        chk({nm, " data_o"}, data_o, ed);
        if (wr || !eh) begin
            chk({nm, " mem_pulses"}, 32'(en_cnt), 32'd1);
            chk({nm, " mem_pulse_cycle"}, 32'(en_k), 32'd1);
            chk({nm, " mem_kind_write"}, {31'b0, en_w}, {31'b0, wr});
            chk({nm, " mem_addr"}, {20'b0, en_a}, {20'b0, a[11:2], 2'b00});
        end else begin
            chk({nm, " mem_pulses"}, 32'(en_cnt), 32'd0);
        end
        @(posedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " done"}, {31'b0, done}, 32'd0);
        chk({nm, " hit"}, {31'b0, hit}, 32'd0);
        chk({nm, " data_o"}, data_o, 32'd0);
        chk({nm, " mem_read_en"}, {31'b0, mem_read_en}, 32'd0);
        chk({nm, " mem_write_en"}, {31'b0, mem_write_en}, 32'd0);
        chk({nm, " mem_addr"}, {20'b0, mem_addr}, 32'd0);
        chk({nm, " mem_data_o"}, mem_data_o, 32'd0);
        chk({nm, " mem_data_en"}, {28'b0, mem_data_en}, 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          mlat;
        logic        exp_hit;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic        eh;
        logic [31:0] ed;
        int          el;
        bit          done_seen;
        int          bad;

        tbl.push_back('{1'b0, 1'b1, 12'h040, 32'h0, 4'h0, 1, 1'b0, init_word(16), 3});
        tbl.push_back('{1'b0, 1'b1, 12'h040, 32'h0, 4'h0, 1, 1'b1, init_word(16), 1});
        tbl.push_back('{1'b1, 1'b0, 12'h040, 32'hAABBCCDD, 4'b0101, 1, 1'b1, 32'h0, 3});
        tbl.push_back('{1'b0, 1'b1, 12'h040, 32'h0, 4'h0, 1, 1'b1, merge(init_word(16), 32'hAABBCCDD, 4'b0101), 1});
        tbl.push_back('{1'b1, 1'b0, 12'h080, 32'h11223344, 4'hF, 1, 1'b0, 32'h0, 3});
        tbl.push_back('{1'b0, 1'b1, 12'h080, 32'h0, 4'h0, 1, 1'b0, 32'h11223344, 3});
        tbl.push_back('{1'b1, 1'b0, 12'h080, 32'h00000099, 4'b0001, 1, 1'b1, 32'h0, 3});
        tbl.push_back('{1'b0, 1'b1, 12'h080, 32'h0, 4'h0, 1, 1'b1, 32'h11223399, 1});
        tbl.push_back('{1'b0, 1'b1, 12'h000, 32'h0, 4'h0, 1, 1'b0, init_word(0), 3});
        tbl.push_back('{1'b0, 1'b1, 12'h100, 32'h0, 4'h0, 1, 1'b0, init_word(64), 3});
        tbl.push_back('{1'b0, 1'b1, 12'h000, 32'h0, 4'h0, 1, 1'b0, init_word(0), 3});
        tbl.push_back('{1'b1, 1'b0, 12'h000, 32'hDEADBEEF, 4'h0, 1, 1'b1, 32'h0, 3});
        tbl.push_back('{1'b0, 1'b1, 12'h000, 32'h0, 4'h0, 1, 1'b1, init_word(0), 1});
        tbl.push_back('{1'b1, 1'b1, 12'h004, 32'h55667788, 4'hF, 2, 1'b0, 32'h0, 4});
        tbl.push_back('{1'b0, 1'b1, 12'h004, 32'h0, 4'h0, 1, 1'b0, 32'h55667788, 3});
        tbl.push_back('{1'b0, 1'b1, 12'hFFC, 32'h0, 4'h0, 3, 1'b0, init_word(1023), 5});
        tbl.push_back('{1'b0, 1'b1, 12'hFFC, 32'h0, 4'h0, 3, 1'b1, init_word(1023), 1});

        for (int w = 0; w < WORDS; w++) begin
            mem[w]     = init_word(w);
            exp_mem[w] = init_word(w);
        end

        reset = 1'b1; addr = '0; data_i = '0; data_en = '0;
        write_en = 1'b0; read_en = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            mem_lat = tbl[i].mlat;
            model_access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, eh, ed, el);
            run_access($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata,
                       tbl[i].be, tbl[i].exp_hit, tbl[i].exp_data, tbl[i].exp_lat);
        end

        // flush together with a request is ignored: 0x40 still hits
        mem_lat = 1;
        flush = 1'b1;
        model_access(1'b0, 12'h040, 32'h0, 4'h0, eh, ed, el);
        run_access("flush_with_req", 1'b0, 1'b1, 12'h040, 32'h0, 4'h0, eh, ed, el);
        flush = 1'b0;

        // flush pulse in IDLE, then 0x40 misses
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        cached.delete();
        model_access(1'b0, 12'h040, 32'h0, 4'h0, eh, ed, el);
        run_access("after_flush", 1'b0, 1'b1, 12'h040, 32'h0, 4'h0, eh, ed, el);

        // reset during MEM_WAIT: no done, late mem_done ignored, cache empty
        mem_lat = 4;
        addr = 12'h200; read_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        read_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cached.delete();
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) check_reset_outputs("reset_mid");
            if (done) done_seen = 1;
        end
        chk("reset_mid no_done", {31'b0, done_seen}, 32'd0);
        @(posedge clk);
        #1;
        mem_lat = 1;
        model_access(1'b0, 12'h040, 32'h0, 4'h0, eh, ed, el);
        run_access("after_reset_mid", 1'b0, 1'b1, 12'h040, 32'h0, 4'h0, eh, ed, el);

        // randomized traffic over a small address pool to get aliasing and hits
        noise = 1;
        for (int n = 0; n < 300; n++) begin
            int r, tg, ix;
            logic wr, rd;
            logic [11:0] a;
            logic [31:0] d;
            logic [3:0] be;
            if ($urandom_range(0, 19) == 0) begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
                cached.delete();
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            r  = $urandom_range(0, 99);
            wr = (r < 35);
            rd = (r < 5) || !wr;
            tg = $urandom_range(0, 3);
            ix = $urandom_range(0, 7);
            a  = 12'(tg * 256 + ix * 4);
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            mem_lat = $urandom_range(1, 3);
            model_access(wr, a, d, be, eh, ed, el);
            run_access($sformatf("rnd%0d", n), wr, rd, a, d, be, eh, ed, el);
        end
        noise = 0;
        repeat (6) @(posedge clk);

        bad = 0;
        for (int w = 0; w < WORDS; w++) if (mem[w] !== exp_mem[w]) bad++;
        chk("memory_contents mismatched_words", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line. It sits between the CPU data port and port B of the dual-port main memory. Toward the CPU it presents the same request/done signalling as memory port B. It reduces read latency on hits from the memory round trip to one cycle.

## Interface
- MEM_SIZE, default MAIN_RAM_SIZE; bytes of backing RAM; address width AW = $clog2(MEM_SIZE).
- NUM_LINES, default 64; line count, power of two ≥ 2; IW = $clog2(NUM_LINES).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- addr  in  AW  CPU byte address; bits [1:0] ignored
- data_i  in  32  CPU write data
- data_en  in  4  byte enables for writes, bit n covers byte lane [8n+7:8n]
- write_en  in  1  CPU write request
- read_en  in  1  CPU read request
- flush  in  1  invalidate all lines; honoured only in IDLE
- data_o  out  32  read data, valid while done=1
- hit  out  1  the completing access hit; valid while done=1
- done  out  1  one-cycle completion pulse
- mem_addr  out  AW  to memory addr_b
- mem_data_o  out  32  to memory data_i_b
- mem_data_en  out  4  to memory data_en_b
- mem_write_en  out  1  to memory write_en_b
- mem_read_en  out  1  to memory read_en_b
- mem_data_i  in  32  from memory data_o_b
- mem_done  in  1  from memory done_b

## Operation
- Address split:
  - index = addr[IW+1:2]
  - tag = addr[AW-1:IW+2]
- Per line: valid bit, tag, 32-bit data. All storage is registers; lookup is combinational in IDLE.
- Requests are latched in IDLE. The CPU holds addr, data_i, data_en and the enables stable until it sees done.
- A request with both write_en and read_en asserted is a write. data_o is 0 for that request.
- FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP.
  - IDLE, flush=1, no request: clear all valid bits and stay in IDLE. flush has priority over a simultaneous request only if no request is present; otherwise flush is ignored.
  - IDLE, read, lookup hit: go to RESP with data_o = line data and hit=1.
  - IDLE, read miss or any write: latch the request and go to MEM_REQ.
  - MEM_REQ: drive mem_read_en or mem_write_en high for exactly this cycle, along with mem_addr, mem_data_o and mem_data_en. Go to MEM_WAIT.
  - MEM_WAIT: hold all mem enables low. Stay until mem_done=1, then:
    - Read miss: write line := {valid=1, tag, mem_data_i}; data_o = mem_data_i; hit=0.
    - Write hit: merge enabled bytes of data_i into the line data; tag and valid unchanged; hit=1.
    - Write miss: no cache change; hit=0.
  - Then go to RESP in every case.
  - RESP: done=1 for exactly one cycle, then IDLE.
- mem_data_i is sampled only when mem_done=1 in MEM_WAIT. mem_done in any other state is ignored.
- A write with data_en=0 still performs the memory transaction; the line is unchanged.

## Timing
- Read hit: request in cycle 0 (IDLE); done=1 in cycle 1.
- Miss or write: MEM_REQ in cycle 1, mem_done expected in cycle 2, done=1 in cycle 3. Each additional cycle of mem_done delay adds one cycle.
- Back-to-back: a new request held at the cycle after RESP is accepted in that IDLE cycle. There is no dead cycle beyond RESP→IDLE.
- done, hit, data_o and mem_* are all registered outputs.
- Reset values:
  - state=IDLE; all valid bits=0.
  - done=0, hit=0, data_o=0.
  - mem_read_en=0, mem_write_en=0, mem_addr=0, mem_data_o=0, mem_data_en=0.
- Reset in any state aborts the access: no done is issued, a pending fill is discarded, and the cache comes up empty. A memory write already issued in MEM_REQ may still complete in memory.
- Tag and valid hold across addr wrap; addresses aliasing to the same index evict each other.

## Test plan
- After reset, read 0x40 -> miss; mem_read_en pulse at cycle 1; done at cycle 3 with hit=0 and data = memory word. Repeat read -> done at cycle 1 with hit=1 and the same data.
- Read 0x40, then write 0x40 with data 0xAABBCCDD, data_en=4'b0101 -> memory write issued; hit=1. Next read of 0x40 -> hit with bytes 0 and 2 updated and bytes 1 and 3 unchanged.
- Write 0x80 (not cached) -> memory updated, hit=0. Read 0x80 -> miss, proving no allocate.
- NUM_LINES=64: read 0x0, then read 0x100 (same index, different tag) -> both miss. Read 0x0 again -> miss.
- Fill 0x40, pulse flush in IDLE, read 0x40 -> miss. Assert reset in MEM_WAIT -> no done pulse; the late mem_done is ignored; the next read misses.
